activation_layer_1: RTL and testbench

ACTIVATION_LAYER_1 -- requirements
Module: activation_layer_1

---
 rtl/activation_layer_1.sv | 137 +++++++++++++
 tb/tb_activation_layer_1.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_layer_1.sv
// Activation layer 1: ReLU with round-half-up requantisation of a dense_layer_1 result,
// one element per cycle, publishing the whole vector plus a saturation count at once.
module activation_layer_1 #(
   parameter int unsigned VEC_SIZE = 32,
   parameter int unsigned IN_W     = 24,
   parameter int unsigned OUT_W    = 16,
   parameter int unsigned SHIFT    = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [VEC_SIZE*IN_W-1:0]          input_vector,
   output logic                              out_valid,
   output logic [VEC_SIZE*OUT_W-1:0]         output_vector,
   output logic [$clog2(VEC_SIZE+1)-1:0]     sat_count
);

   localparam int unsigned IDX_W = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
   localparam int unsigned CNT_W = $clog2(VEC_SIZE + 1);
   localparam logic [IN_W:0] ROUND   = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic [IN_W:0] MAX_POS = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};

   typedef enum logic [1:0] {IDLE, PROC, DONE} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               last_q, last_d;
   logic [IN_W-1:0]    snap_q [VEC_SIZE];
   logic [OUT_W-1:0]   buf_q  [VEC_SIZE];
   logic [OUT_W-1:0]   out_q  [VEC_SIZE];
   logic [CNT_W-1:0]   cnt_q, sat_q;

   logic               accept, step, finish;
   logic [IN_W-1:0]    x;
   logic [IN_W:0]      sum, y;
   logic [OUT_W-1:0]   res;
   logic               sat;

   // Control. last_q marks that the final element has been written, giving the buffer
   // one settled cycle before it is copied to the outputs.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      accept  = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = PROC;
               idx_d   = '0;
               last_d  = 1'b0;
            end
         end
         PROC: begin
            if (last_q) begin
               finish  = 1'b1;
               state_d = DONE;
            end else begin
               step = 1'b1;
               if (idx_q == IDX_W'(VEC_SIZE - 1)) begin
                  last_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-element ReLU, rounding shift and clamp; sum is one bit wider so it cannot overflow.
   always_comb begin
      x   = snap_q[idx_q];
      sum = {1'b0, x} + ROUND;
      y   = sum >> SHIFT;
      res = '0;
      sat = 1'b0;
      if (!x[IN_W-1]) begin
         if (y > MAX_POS) begin
            res = MAX_POS[OUT_W-1:0];
            sat = 1'b1;
         end else begin
            res = y[OUT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         sat_q   <= '0;
         for (int unsigned i = 0; i < VEC_SIZE; i++) begin
            snap_q[i] <= '0;
            buf_q[i]  <= '0;
            out_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         if (accept) begin
            cnt_q <= '0;
            for (int unsigned i = 0; i < VEC_SIZE; i++) begin
               snap_q[i] <= input_vector[i*IN_W +: IN_W];
            end
         end
         if (step) begin
            buf_q[idx_q] <= res;
            if (sat) cnt_q <= cnt_q + 1'b1;
         end
         if (finish) begin
            out_q <= buf_q;
            sat_q <= cnt_q;
         end
      end
   end

   always_comb begin
      output_vector = '0;
      for (int unsigned i = 0; i < VEC_SIZE; i++) begin
         output_vector[i*OUT_W +: OUT_W] = out_q[i];
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sat_count = sat_q;

endmodule

// File: tb/tb_activation_layer_1.sv
// Bench for activation_layer_1: timeline model of accept/publish plus arithmetic reference,
// directed boundary vectors and randomized traffic with occasional resets.
module tb_activation_layer_1;

   localparam int VEC_SIZE = 32;
   localparam int IN_W     = 24;
   localparam int OUT_W    = 16;
   localparam int SHIFT    = 8;
   localparam int IW       = VEC_SIZE * IN_W;
   localparam int OW       = VEC_SIZE * OUT_W;
   localparam int CW       = $clog2(VEC_SIZE + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] input_vector;
   logic          out_valid;
   logic [OW-1:0] output_vector;
   logic [CW-1:0] sat_count;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   activation_layer_1 #(
      .VEC_SIZE (VEC_SIZE),
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .SHIFT    (SHIFT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .input_vector  (input_vector),
      .out_valid     (out_valid),
      .output_vector (output_vector),
      .sat_count     (sat_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic on plain integers.
   function automatic void model_vec(input logic [IW-1:0] v, output logic [OW-1:0] o,
                                     output int s);
      longint x, y, maxv;
      maxv = (longint'(1) << (OUT_W - 1)) - 1;
      s = 0;
      o = '0;
      for (int i = 0; i < VEC_SIZE; i++) begin
         x = longint'($signed(v[i*IN_W +: IN_W]));
         if (x <= 0) begin
            y = 0;
         end else begin
            y = (x + (longint'(1) << (SHIFT - 1))) / (longint'(1) << SHIFT);
            if (y > maxv) begin
               y = maxv;
               s++;
            end
         end
         o[i*OUT_W +: OUT_W] = y[OUT_W-1:0];
      end
   endfunction

   // Timeline model: accepted vector is published VEC_SIZE+1 edges after acceptance,
   // and the block is free again one edge later.
   bit            m_busy = 1'b0;
   int            m_age  = 0;
   logic [OW-1:0] m_out  = '0;
   int            m_sat  = 0;
   logic [OW-1:0] m_pend;
   int            m_pend_sat;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
         m_age  = 0;
         m_out  = '0;
         m_sat  = 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy = 1'b1;
            m_age  = 0;
            model_vec(input_vector, m_pend, m_pend_sat);
         end
      end else begin
         m_age++;
         if (m_age == VEC_SIZE + 1) begin
            m_out = m_pend;
            m_sat = m_pend_sat;
         end
         if (m_age == VEC_SIZE + 2) m_busy = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", OW'(in_ready), OW'(!m_busy));
         check("out_valid", OW'(out_valid), OW'(m_busy && m_age == VEC_SIZE + 1));
         check("output_vector", output_vector, m_out);
         check("sat_count", OW'(sat_count), OW'(m_sat));
      end
   end

   task automatic send(input logic [IW-1:0] v);
      @(posedge clk);
      #1;
      input_vector = v;
      in_valid     = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_pulse(input string name, input int exp_edges);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         seen = out_valid;
      end
      check(name, OW'(n), OW'(exp_edges));
   endtask

   function automatic logic [IN_W-1:0] rand_elem();
      logic [IN_W-1:0] e;
      case ($urandom_range(0, 3))
         0:       e = IN_W'($urandom);
         1:       e = IN_W'($urandom_range(0, 1000));
         2:       e = IN_W'(32'h7FFF00 + $urandom_range(0, 255));
         default: e = IN_W'(-$urandom_range(1, 600));
      endcase
      return e;
   endfunction

   function automatic logic [IW-1:0] rand_vec();
      logic [IW-1:0] v;
      for (int i = 0; i < VEC_SIZE; i++) v[i*IN_W +: IN_W] = rand_elem();
      return v;
   endfunction

   logic [IW-1:0] vec;
   int            last_pulse;
   int            npulse;
   int            cyc;

   initial begin
      rst          = 1'b1;
      in_valid     = 1'b0;
      input_vector = '0;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_in_ready", OW'(in_ready), OW'(1));
      check("reset_out_valid", OW'(out_valid), OW'(0));
      check("reset_outputs", output_vector, '0);
      check("reset_sat", OW'(sat_count), OW'(0));

      // All 256: each rounds to 1.
      for (int i = 0; i < VEC_SIZE; i++) vec[i*IN_W +: IN_W] = IN_W'(256);
      send(vec);
      wait_pulse("latency_256", 33);
      check("v256_e0", OW'(output_vector[0 +: OUT_W]), OW'(1));
      check("v256_e31", OW'(output_vector[31*OUT_W +: OUT_W]), OW'(1));
      check("v256_sat", OW'(sat_count), OW'(0));

      // Negative, 383, negative, 384 pattern.
      for (int i = 0; i < VEC_SIZE; i++) begin
         case (i % 4)
            0, 2:    vec[i*IN_W +: IN_W] = IN_W'(-5000);
            1:       vec[i*IN_W +: IN_W] = IN_W'(383);
            default: vec[i*IN_W +: IN_W] = IN_W'(384);
         endcase
      end
      send(vec);
      wait_pulse("latency_alt", 33);
      check("alt_neg", OW'(output_vector[0 +: OUT_W]), OW'(0));
      check("alt_383", OW'(output_vector[1*OUT_W +: OUT_W]), OW'(1));
      check("alt_384", OW'(output_vector[3*OUT_W +: OUT_W]), OW'(2));

      for (int i = 0; i < VEC_SIZE; i++) vec[i*IN_W +: IN_W] = 24'h7FFFFF;
      send(vec);
      wait_pulse("latency_max", 33);
      check("max_e5", OW'(output_vector[5*OUT_W +: OUT_W]), OW'(32767));
      check("max_sat", OW'(sat_count), OW'(32));

      for (int i = 0; i < VEC_SIZE; i++) vec[i*IN_W +: IN_W] = 24'h7FFF7F;
      send(vec);
      wait_pulse("latency_edge", 33);
      check("edge_e7", OW'(output_vector[7*OUT_W +: OUT_W]), OW'(32767));
      check("edge_sat", OW'(sat_count), OW'(0));

      // Reset while element 10 is being processed.
      send(rand_vec());
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready", OW'(in_ready), OW'(1));
      check("abort_outputs", output_vector, '0);
      check("abort_sat", OW'(sat_count), OW'(0));
      for (int i = 0; i < VEC_SIZE; i++) vec[i*IN_W +: IN_W] = IN_W'(1000 + i * 256);
      send(vec);
      wait_pulse("after_abort", 33);
      check("after_abort_e0", OW'(output_vector[0 +: OUT_W]), OW'(4));

      // in_valid held high with the vector changing every cycle.
      @(posedge clk);
      #1;
      input_vector = rand_vec();
      in_valid     = 1'b1;
      last_pulse   = -1;
      npulse       = 0;
      for (int k = 1; k <= 150; k++) begin
         @(posedge clk);
         #1;
         input_vector = rand_vec();
         @(negedge clk);
         if (out_valid) begin
            if (last_pulse >= 0) check("pulse_gap", OW'(k - last_pulse), OW'(35));
            last_pulse = k;
            npulse++;
         end
      end
      check("pulse_count", OW'(npulse), OW'(4));
      #1;
      in_valid = 1'b0;

      // Random traffic with sparse resets.
      cyc = 0;
      while (cyc < 1500) begin
         @(posedge clk);
         #1;
         input_vector = rand_vec();
         in_valid     = ($urandom_range(0, 9) < 3);
         rst          = ($urandom_range(0, 199) == 0);
         cyc++;
      end
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
